// File: rtl/secure_accum_if.sv
// secure_accum_if -- command/debug bundle between the sequencer, the debug
// access logic and secure_accum_core.
//   execute/instruction/op/acc_sel -> command strobe and operand
//   result/carry                   <- registered command outcome
//   dbg_req/dbg_key                -> unlock/relock attempt
//   dbg_rd/dbg_sel                 -> debug read of an accumulator or last instruction
//   dbg_data/dbg_unlocked/dbg_lockout <- debug read data and lock status
interface secure_accum_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_ACC = 4
);
  localparam int SEL_W  = $clog2(NUM_ACC);
  localparam int DSEL_W = $clog2(NUM_ACC + 1);

  logic              execute;
  logic [DATA_W-1:0] instruction;
  logic [1:0]        op;
  logic [SEL_W-1:0]  acc_sel;
  logic [DATA_W-1:0] result;
  logic              carry;
  logic              dbg_req;
  logic [DATA_W-1:0] dbg_key;
  logic              dbg_rd;
  logic [DSEL_W-1:0] dbg_sel;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_unlocked;
  logic              dbg_lockout;

  modport master (
    output execute, instruction, op, acc_sel, dbg_req, dbg_key, dbg_rd, dbg_sel,
    input  result, carry, dbg_data, dbg_unlocked, dbg_lockout
  );

  modport slave (
    input  execute, instruction, op, acc_sel, dbg_req, dbg_key, dbg_rd, dbg_sel,
    output result, carry, dbg_data, dbg_unlocked, dbg_lockout
  );
endinterface

// File: rtl/secure_accum_core.sv
// secure_accum_core -- NUM_ACC accumulators updated on the rising edge of
// execute (ADD/SUB/LOAD/CLEAR), with internal state visible only through a
// key-gated debug port that relocks on timeout/request and locks out
// permanently after MAX_FAIL consecutive bad keys.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : secure_accum_if slave (command, result, debug port)
module secure_accum_core #(
  parameter int          DATA_W   = 32,
  parameter int          NUM_ACC  = 4,
  parameter logic [31:0] DBG_KEY  = 32'hA5C3_0F1E,
  parameter int          MAX_FAIL = 3,
  parameter int          TIMEOUT  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  secure_accum_if.slave bus
);
  localparam int SEL_W  = $clog2(NUM_ACC);
  localparam int DSEL_W = $clog2(NUM_ACC + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] KEY = DATA_W'(DBG_KEY);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LD  = 2'b10;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } dbg_st_e;

  // ---------------- command path ----------------
  logic                           r_exec_q;
  logic                           w_exec_edge;
  logic [NUM_ACC-1:0][DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]              r_last;
  logic [DATA_W-1:0]              r_result;
  logic                           r_carry;
  logic [DATA_W-1:0]              w_acc_cur;
  logic [DATA_W:0]                w_sum;
  logic [DATA_W:0]                w_diff;
  logic [DATA_W-1:0]              w_new;
  logic                           w_carry_new;

  assign w_exec_edge = bus.execute & ~r_exec_q;

  always_comb begin
    w_acc_cur   = r_acc[bus.acc_sel];
    w_sum       = {1'b0, w_acc_cur} + {1'b0, bus.instruction};
    // Top bit of the widened difference is the unsigned borrow.
    w_diff      = {1'b0, w_acc_cur} - {1'b0, bus.instruction};
    w_new       = '0;
    w_carry_new = 1'b0;
    case (bus.op)
      OP_ADD:  begin w_new = w_sum[DATA_W-1:0];  w_carry_new = w_sum[DATA_W];  end
      OP_SUB:  begin w_new = w_diff[DATA_W-1:0]; w_carry_new = w_diff[DATA_W]; end
      OP_LD:   w_new = bus.instruction;
      default: w_new = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exec_q <= 1'b0;
      r_acc    <= '0;
      r_last   <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
    end else begin
      r_exec_q <= bus.execute;
      if (w_exec_edge) begin
        for (int i = 0; i < NUM_ACC; i++)
          if (bus.acc_sel == SEL_W'(i)) r_acc[i] <= w_new;
        r_last   <= bus.instruction;
        r_result <= w_new;
        r_carry  <= w_carry_new;
      end
    end
  end

  assign bus.result = r_result;
  assign bus.carry  = r_carry;

  // ---------------- debug FSM ----------------
  dbg_st_e           r_state, w_state_nxt;
  logic [3:0]        r_fail_cnt;
  logic [3:0]        w_fail_inc;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic              w_key_ok;
  logic              w_idle_last;
  logic [DATA_W-1:0] w_dbg_val;
  logic [DATA_W-1:0] r_dbg_data;

  assign w_key_ok    = (bus.dbg_key == KEY);
  assign w_fail_inc  = r_fail_cnt + 4'd1;
  assign w_idle_last = (r_idle_cnt == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_LOCKED;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOCKED:
        if (bus.dbg_req) begin
          if (w_key_ok)                         w_state_nxt = ST_UNLOCKED;
          else if (w_fail_inc == 4'(MAX_FAIL))  w_state_nxt = ST_LOCKOUT;
        end
      ST_UNLOCKED:
        // Any request relocks; otherwise relock when this idle cycle is the TIMEOUT-th.
        if (bus.dbg_req || (!bus.dbg_rd && w_idle_last)) w_state_nxt = ST_LOCKED;
      ST_LOCKOUT:  w_state_nxt = ST_LOCKOUT;
      default:     w_state_nxt = ST_LOCKED;
    endcase
  end

  always_comb begin
    bus.dbg_unlocked = (r_state == ST_UNLOCKED);
    bus.dbg_lockout  = (r_state == ST_LOCKOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_cnt <= '0;
      r_idle_cnt <= '0;
    end else begin
      case (r_state)
        ST_LOCKED:
          if (bus.dbg_req) begin
            if (w_key_ok) begin
              r_fail_cnt <= '0;
              r_idle_cnt <= '0;
            end else begin
              r_fail_cnt <= w_fail_inc;
            end
          end
        ST_UNLOCKED:
          if (bus.dbg_req || bus.dbg_rd || w_idle_last) r_idle_cnt <= '0;
          else                                          r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_dbg_val = '0;
    if (bus.dbg_sel < DSEL_W'(NUM_ACC))       w_dbg_val = r_acc[bus.dbg_sel[SEL_W-1:0]];
    else if (bus.dbg_sel == DSEL_W'(NUM_ACC)) w_dbg_val = r_last;
  end

  // Read data is wiped whenever the port is not open (or is being relocked)
  // so no secret lingers on dbg_data after a relock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_dbg_data <= '0;
    else if (r_state != ST_UNLOCKED || bus.dbg_req) r_dbg_data <= '0;
    else if (bus.dbg_rd)                           r_dbg_data <= w_dbg_val;
  end

  assign bus.dbg_data = r_dbg_data;
endmodule

// File: tb/tb_secure_accum_core.sv
module tb_secure_accum_core;
  localparam logic [1:0]  OP_ADD = 2'b00;
  localparam logic [1:0]  OP_SUB = 2'b01;
  localparam logic [1:0]  OP_LD  = 2'b10;
  localparam logic [31:0] KEY    = 32'hA5C3_0F1E;
  localparam logic [31:0] BADKEY = 32'h1234_5678;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  secure_accum_if #(.DATA_W(32), .NUM_ACC(4)) bus();

  secure_accum_core #(
    .DATA_W(32), .NUM_ACC(4), .DBG_KEY(KEY), .MAX_FAIL(3), .TIMEOUT(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_exec(input logic [1:0] o, input logic [1:0] s, input logic [31:0] d);
    bus.op = o; bus.acc_sel = s; bus.instruction = d;
    bus.execute = 1'b1;
    tick();
    bus.execute = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.execute = 1'b0; bus.instruction = '0; bus.op = '0; bus.acc_sel = '0;
    bus.dbg_req = 1'b0; bus.dbg_key = '0; bus.dbg_rd = 1'b0; bus.dbg_sel = '0;

    // reset state
    #12;
    chk("rst_result",   bus.result,       32'h0);
    chk("rst_carry",    32'(bus.carry),   32'h0);
    chk("rst_dbg_data", bus.dbg_data,     32'h0);
    chk("rst_unlocked", 32'(bus.dbg_unlocked), 32'h0);
    chk("rst_lockout",  32'(bus.dbg_lockout),  32'h0);
    rst_n = 1'b1;
    tick();

    // 1: add/sub with borrow
    do_exec(OP_ADD, 2'd0, 32'd5);
    chk("add5", bus.result, 32'd5);
    do_exec(OP_ADD, 2'd0, 32'd7);
    chk("add7", bus.result, 32'd12);
    chk("add7_carry", 32'(bus.carry), 32'h0);
    do_exec(OP_SUB, 2'd0, 32'd13);
    chk("sub13", bus.result, 32'hFFFF_FFFF);
    chk("sub13_borrow", 32'(bus.carry), 32'h1);

    // 2: held execute performs one op; op/operand changes while held are ignored
    bus.op = OP_LD; bus.acc_sel = 2'd2; bus.instruction = 32'h0000_DEAD;
    bus.execute = 1'b1;
    tick();
    chk("load_dead", bus.result, 32'h0000_DEAD);
    chk("load_carry", 32'(bus.carry), 32'h0);
    bus.op = OP_ADD; bus.instruction = 32'h1;
    repeat (9) tick();
    chk("held_once", bus.result, 32'h0000_DEAD);
    bus.execute = 1'b0;
    tick();
    do_exec(OP_ADD, 2'd2, 32'hFFFF_2153);
    chk("add_wrap", bus.result, 32'h0);
    chk("add_wrap_carry", 32'(bus.carry), 32'h1);

    // 3: locked read gives 0; unlock and read state
    bus.dbg_sel = 3'd4; bus.dbg_rd = 1'b1;
    tick();
    chk("locked_rd", bus.dbg_data, 32'h0);
    bus.dbg_rd = 1'b0;
    bus.dbg_key = KEY; bus.dbg_req = 1'b1;
    tick();
    bus.dbg_req = 1'b0;
    chk("unlock", 32'(bus.dbg_unlocked), 32'h1);
    bus.dbg_rd = 1'b1; bus.dbg_sel = 3'd4;
    tick();
    chk("rd_last_instr", bus.dbg_data, 32'hFFFF_2153);
    bus.dbg_sel = 3'd0;
    tick();
    chk("rd_acc0", bus.dbg_data, 32'hFFFF_FFFF);
    bus.dbg_sel = 3'd1;
    tick();
    chk("rd_acc1", bus.dbg_data, 32'h0);
    bus.dbg_sel = 3'd4;
    tick();
    bus.dbg_sel = 3'd7;
    tick();
    chk("rd_sel_hi", bus.dbg_data, 32'h0);
    // read and write of acc0 in the same cycle
    bus.dbg_sel = 3'd0;
    bus.op = OP_LD; bus.acc_sel = 2'd0; bus.instruction = 32'h55;
    bus.execute = 1'b1;
    tick();
    chk("rd_pre_update", bus.dbg_data, 32'hFFFF_FFFF);
    chk("load55", bus.result, 32'h55);
    bus.execute = 1'b0;
    tick();
    chk("rd_post_update", bus.dbg_data, 32'h55);
    bus.dbg_rd = 1'b0;

    // 4: idle timeout
    repeat (15) tick();
    chk("idle15_unlocked", 32'(bus.dbg_unlocked), 32'h1);
    chk("idle15_data", bus.dbg_data, 32'h55);
    tick();
    chk("timeout_relock", 32'(bus.dbg_unlocked), 32'h0);
    tick();
    chk("timeout_wipe", bus.dbg_data, 32'h0);

    // 5: lockout after three bad keys, then async reset
    do_exec(OP_SUB, 2'd1, 32'd1);
    chk("sub_acc1", bus.result, 32'hFFFF_FFFF);
    chk("sub_acc1_borrow", 32'(bus.carry), 32'h1);
    bus.dbg_key = BADKEY; bus.dbg_req = 1'b1;
    tick();
    tick();
    chk("bad2_no_lockout", 32'(bus.dbg_lockout), 32'h0);
    tick();
    chk("bad3_lockout", 32'(bus.dbg_lockout), 32'h1);
    bus.dbg_key = KEY;
    tick();
    bus.dbg_req = 1'b0;
    chk("lockout_key_ignored", 32'(bus.dbg_unlocked), 32'h0);
    chk("lockout_sticky", 32'(bus.dbg_lockout), 32'h1);
    bus.dbg_rd = 1'b1; bus.dbg_sel = 3'd0;
    tick();
    chk("lockout_rd", bus.dbg_data, 32'h0);
    bus.dbg_rd = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_result", bus.result, 32'h0);
    chk("arst_carry", 32'(bus.carry), 32'h0);
    chk("arst_lockout", 32'(bus.dbg_lockout), 32'h0);
    chk("arst_unlocked", 32'(bus.dbg_unlocked), 32'h0);
    // an execute edge under reset must not write anything
    bus.op = OP_LD; bus.acc_sel = 2'd1; bus.instruction = 32'hBAD0_BAD0;
    bus.execute = 1'b1;
    tick();
    bus.execute = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    chk("rst_hold_result", bus.result, 32'h0);

    // 6: fail counter cleared by a good key
    do_exec(OP_LD, 2'd3, 32'h1234);
    chk("load1234", bus.result, 32'h1234);
    bus.dbg_key = BADKEY; bus.dbg_req = 1'b1;
    tick();
    tick();
    chk("bad2b_lockout", 32'(bus.dbg_lockout), 32'h0);
    bus.dbg_key = KEY;
    tick();
    bus.dbg_req = 1'b0;
    chk("unlock2", 32'(bus.dbg_unlocked), 32'h1);
    bus.dbg_rd = 1'b1; bus.dbg_sel = 3'd1;
    tick();
    chk("rd_acc1_cleared", bus.dbg_data, 32'h0);
    bus.dbg_sel = 3'd3;
    tick();
    chk("rd_acc3", bus.dbg_data, 32'h1234);
    // relock request together with a read: relock wins
    bus.dbg_key = BADKEY; bus.dbg_req = 1'b1;
    tick();
    chk("relock_unlocked", 32'(bus.dbg_unlocked), 32'h0);
    chk("relock_data", bus.dbg_data, 32'h0);
    bus.dbg_rd = 1'b0;
    tick();
    chk("bad2c_lockout", 32'(bus.dbg_lockout), 32'h0);
    bus.dbg_req = 1'b0;
    chk("bad2c_locked", 32'(bus.dbg_unlocked), 32'h0);
    bus.dbg_key = KEY; bus.dbg_req = 1'b1;
    tick();
    bus.dbg_req = 1'b0;
    chk("unlock3", 32'(bus.dbg_unlocked), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/secure_accum_core.md
Name: secure_accum_core

Overview:
Parametrised successor to the single-accumulator secure processor. It holds NUM_ACC independent accumulators driven by edge-triggered execute commands with selectable opcodes. Internal state, meaning the accumulators and the last instruction, is readable only through a key-gated debug port. That port has a relock timeout and a permanent lockout after repeated bad keys. It sits between the instruction sequencer and the debug/test access logic.

Parameters:
DATA_W, 32, datapath width of instruction, accumulators, key and debug data
NUM_ACC, 4, number of accumulators; power of two, at least 2
DBG_KEY, 32'hA5C3_0F1E, unlock key; only the low DATA_W bits are used
MAX_FAIL, 3, consecutive bad keys that force LOCKOUT; range 1..15
TIMEOUT, 16, idle cycles in UNLOCKED before auto-relock; at least 1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
execute  in  1  command strobe; acts on its rising edge only
instruction  in  DATA_W  operand
op  in  2  operation: 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
acc_sel  in  clog2(NUM_ACC)  target accumulator
result  out  DATA_W  registered value of the accumulator written by the last command
carry  out  1  carry-out for ADD, borrow for SUB, 0 for LOAD/CLEAR; registered
dbg_req  in  1  unlock attempt strobe, sampled every cycle it is high
dbg_key  in  DATA_W  key presented with dbg_req
dbg_rd  in  1  debug read strobe
dbg_sel  in  clog2(NUM_ACC+1)  0..NUM_ACC-1 selects an accumulator; NUM_ACC selects the last instruction; higher values read 0
dbg_data  out  DATA_W  registered debug read data
dbg_unlocked  out  1  high in UNLOCKED
dbg_lockout  out  1  high in LOCKOUT

Behaviour:
- Reset (asynchronous, rst_n low) clears all of the following:
  - all accumulators, the last-instruction register, result, carry and dbg_data go to 0
  - the execute edge register goes to 0
  - the fail counter and idle counter go to 0
  - the FSM goes to LOCKED
- Reset asserted mid-operation discards any pending update, and nothing is written that cycle.
- Edge detect: exec_edge = execute & ~execute_q, where execute_q is execute registered. Holding execute high for N cycles performs exactly one operation.
- On exec_edge the following all update at the same clk edge, so the new result is visible the cycle after the edge:
  - acc[acc_sel] takes its new value
  - result takes the new value
  - carry takes its new value
  - last_instr takes instruction
- Opcode arithmetic, modulo 2^DATA_W (wraps):
  - ADD: acc + instruction, carry = bit DATA_W of the sum
  - SUB: acc - instruction, carry = 1 when acc < instruction (unsigned)
  - LOAD: instruction
  - CLEAR: 0
- Accumulators not selected are unchanged. result and carry hold their values between commands.
- Debug FSM transitions:
  - LOCKED, dbg_req with key == DBG_KEY: go to UNLOCKED; fail counter and idle counter reset to 0.
  - LOCKED, dbg_req with a bad key: fail counter increments. When it reaches MAX_FAIL, go to LOCKOUT.
  - UNLOCKED, dbg_req with any key: go to LOCKED (explicit relock); the fail counter is unchanged.
  - UNLOCKED, idle counter: increments on every cycle without dbg_rd and clears on dbg_rd. On reaching TIMEOUT, go to LOCKED.
  - LOCKOUT: terminal; only reset exits it.
- Debug reads:
  - In UNLOCKED, dbg_rd loads dbg_data with the selected value on the next edge (1-cycle latency). Without dbg_rd, dbg_data holds.
  - Any state other than UNLOCKED forces dbg_data to 0 on the next edge, so no stale secret persists after relock.
- Simultaneous events:
  - dbg_req together with dbg_rd in UNLOCKED: the relock wins and dbg_data is 0.
  - exec_edge together with dbg_rd on the same accumulator: dbg_data returns the pre-update value.
  - execute operates regardless of debug state.

Test Plan:
1. After reset: ADD 5 to acc0, ADD 7 to acc0 -> result=12, carry=0. Then SUB 13 from acc0 -> result=32'hFFFF_FFFF, carry=1; acc1 still 0.
2. Hold execute high for 10 cycles with LOAD 0xDEAD to acc2 -> exactly one write. Then ADD 32'hFFFF_2153 -> result=0, carry=1.
3. While LOCKED, dbg_rd of sel=NUM_ACC -> dbg_data=0. Unlock with DBG_KEY, then read sel=NUM_ACC -> returns the last instruction a cycle later; dbg_unlocked=1.
4. In UNLOCKED, leave dbg_rd idle for TIMEOUT cycles -> dbg_unlocked drops on the TIMEOUT-th cycle and dbg_data becomes 0 the next cycle.
5. Present 3 bad keys -> dbg_lockout=1. A subsequent correct key still reads 0. Pulse rst_n low asynchronously (mid-cycle) -> LOCKED, all outputs 0.
6. Two bad keys then the correct key -> unlocked, fail counter 0. Two more bad keys after relock -> still LOCKED, no lockout.
